// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the buffered UART transmit path
// Ports: none (package)
package uart_pkg;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} tx_fifo_state_t;
  localparam int DATA_BITS = 8;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered head read and registered flags
// Ports: clk/rst; push+wr_data write; pop loads rd_data from the head on the same edge;
//        count, full, empty describe the stored entries
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      wr_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] next_count;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign next_count = count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      rd_data <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      count <= next_count;
      full <= next_count == (AW+1)'(DEPTH);
      empty <= next_count == '0;
      rd_data <= do_pop ? mem[rd_ptr] : rd_data;
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffers pushed bytes and launches them into uart_tx one at a time, paced by its busy flag
// Ports: clk/rst; i_data_valid+i_data push side with o_full/o_empty/o_count/o_overflow status;
//        o_tx_data_valid+o_tx_data launch toward uart_tx, i_tx_busy is uart_tx o_busy
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS = uart_pkg::DATA_BITS,
  parameter int DEPTH = 16,
  parameter int BUSY_WAIT_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_data_valid,
  input  logic [DATA_BITS-1:0]   i_data,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic                   o_tx_data_valid,
  output logic [DATA_BITS-1:0]   o_tx_data,
  input  logic                   i_tx_busy
);
  localparam int GW = $clog2(BUSY_WAIT_CYCLES + 2);
  tx_fifo_state_t state, next_state;
  logic [GW-1:0] guard;
  logic [DATA_BITS-1:0] head;
  logic pop;
  assign pop = state == IDLE && !o_empty && !i_tx_busy;
  sync_fifo #(.DATA_WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(i_data_valid),
    .wr_data(i_data),
    .pop(pop),
    .rd_data(head),
    .count(o_count),
    .full(o_full),
    .empty(o_empty)
  );
  always_comb begin
    next_state = state;
    case (state)
      IDLE:      next_state = pop ? LAUNCH : IDLE;
      LAUNCH:    next_state = WAIT_BUSY;
      // uart_tx that never raises busy must not stall the queue forever
      WAIT_BUSY: next_state = i_tx_busy ? WAIT_DONE : (guard <= GW'(1)) ? IDLE : WAIT_BUSY;
      WAIT_DONE: next_state = i_tx_busy ? WAIT_DONE : IDLE;
      default:   next_state = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      guard <= '0;
      o_overflow <= 1'b0;
      o_tx_data_valid <= 1'b0;
      o_tx_data <= '0;
    end else begin
      state <= next_state;
      guard <= state == LAUNCH ? GW'(BUSY_WAIT_CYCLES) : (state == WAIT_BUSY && !i_tx_busy) ? guard - GW'(1) : guard;
      o_overflow <= i_data_valid && o_full;
      o_tx_data_valid <= state == LAUNCH;
      o_tx_data <= state == LAUNCH ? head : o_tx_data;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: randomized and directed self-checking bench with a queue-based reference model
module tb_uart_tx_fifo;
  logic clk = 0;
  logic rst = 1;
  logic i_data_valid = 0;
  logic [7:0] i_data = 0;
  logic o_full, o_empty, o_overflow, o_tx_data_valid;
  logic [4:0] o_count;
  logic [7:0] o_tx_data;
  logic i_tx_busy;
  logic hold_busy = 0;
  logic model_busy = 0;
  logic model_en = 1;
  logic prev_busy = 0;
  int blen = 20;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  int tx_cyc[$];

  assign i_tx_busy = hold_busy | model_busy;

  uart_tx_fifo dut (
    .clk(clk),
    .rst(rst),
    .i_data_valid(i_data_valid),
    .i_data(i_data),
    .o_full(o_full),
    .o_empty(o_empty),
    .o_count(o_count),
    .o_overflow(o_overflow),
    .o_tx_data_valid(o_tx_data_valid),
    .o_tx_data(o_tx_data),
    .i_tx_busy(i_tx_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // uart_tx stand-in: busy rises two cycles after a launch and lasts blen cycles
  always @(posedge clk)
    if (model_en && o_tx_data_valid) begin
      repeat (2) @(posedge clk);
      model_busy <= 1;
      repeat (blen) @(posedge clk);
      model_busy <= 0;
    end

  always @(negedge clk)
    if (!rst) begin
      if (o_tx_data_valid) begin
        tx_log.push_back(o_tx_data);
        tx_cyc.push_back(cyc);
        check("launch_busy_low", int'(i_tx_busy), 0);
        check("launch_after_fall", int'(prev_busy), 0);
      end
      prev_busy = i_tx_busy;
    end

  task automatic push(input logic [7:0] d);
    i_data_valid = 1;
    i_data = d;
    @(posedge clk);
    #1;
    i_data_valid = 0;
  endtask

  task automatic drain(input int n);
    int k = 0;
    while (!(tx_log.size() >= n && o_empty && !i_tx_busy) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    check("drain_timeout", int'(k < 3000), 1);
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic cmp_log(input string tag);
    int n = exp_q.size() < tx_log.size() ? exp_q.size() : tx_log.size();
    check({tag, "_len"}, tx_log.size(), exp_q.size());
    for (int i = 0; i < n; i++) check({tag, "_data"}, int'(tx_log[i]), int'(exp_q[i]));
    exp_q.delete();
    tx_log.delete();
    tx_cyc.delete();
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    check("rst_count", int'(o_count), 0);
    check("rst_empty", int'(o_empty), 1);
    check("rst_full", int'(o_full), 0);
    check("rst_ovf", int'(o_overflow), 0);
    check("rst_valid", int'(o_tx_data_valid), 0);
    check("rst_data", int'(o_tx_data), 0);

    push(8'h55);
    exp_q.push_back(8'h55);
    check("single_n1", int'(o_tx_data_valid), 0);
    @(posedge clk); #1;
    check("single_n2", int'(o_tx_data_valid), 0);
    @(posedge clk); #1;
    check("single_valid", int'(o_tx_data_valid), 1);
    check("single_data", int'(o_tx_data), 8'h55);
    @(posedge clk); #1;
    check("single_one_cycle", int'(o_tx_data_valid), 0);
    repeat (40) @(posedge clk);
    #1;
    check("single_empty", int'(o_empty), 1);
    cmp_log("single");

    blen = 6;
    for (int i = 1; i <= 5; i++) begin
      push(8'(i));
      exp_q.push_back(8'(i));
    end
    drain(5);
    cmp_log("burst");

    hold_busy = 1;
    for (int i = 0; i <= 16; i++) begin
      push(8'(i));
      if (i < 16) exp_q.push_back(8'(i));
      check("ovf_full", int'(o_full), int'(i >= 15));
      check("ovf_pulse", int'(o_overflow), int'(i == 16));
    end
    check("ovf_count", int'(o_count), 16);
    @(posedge clk); #1;
    check("ovf_once", int'(o_overflow), 0);
    hold_busy = 0;
    drain(16);
    cmp_log("ovf");

    hold_busy = 1;
    for (int i = 0; i < 3; i++) begin
      push(8'h31 + 8'(i));
      exp_q.push_back(8'h31 + 8'(i));
    end
    check("sim_count3", int'(o_count), 3);
    hold_busy = 0;
    push(8'h3C);
    exp_q.push_back(8'h3C);
    check("sim_count_kept", int'(o_count), 3);
    drain(4);
    cmp_log("sim");

    model_en = 0;
    push(8'hA0);
    push(8'hA1);
    exp_q.push_back(8'hA0);
    exp_q.push_back(8'hA1);
    drain(2);
    if (tx_cyc.size() == 2) check("guard_gap", int'(tx_cyc[1] - tx_cyc[0] >= 6), 1);
    else check("guard_pulses", tx_cyc.size(), 2);
    cmp_log("guard");
    model_en = 1;

    blen = 10;
    for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i));
    n = 0;
    while (!model_busy && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("rst_mid_busy_seen", int'(model_busy), 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    check("rst_mid_count", int'(o_count), 0);
    check("rst_mid_empty", int'(o_empty), 1);
    check("rst_mid_valid", int'(o_tx_data_valid), 0);
    n = tx_log.size();
    repeat (100) @(posedge clk);
    #1;
    check("rst_mid_no_launch", tx_log.size(), n);
    tx_log.delete();
    tx_cyc.delete();

    for (int b = 0; b < 6; b++) begin
      int len = $urandom_range(1, 12);
      int sent = 0;
      blen = $urandom_range(1, 8);
      while (sent < len) begin
        if ($urandom_range(0, 2) != 0) begin
          logic [7:0] d = 8'($urandom);
          push(d);
          exp_q.push_back(d);
          sent++;
        end else begin
          @(posedge clk); #1;
        end
      end
      drain(exp_q.size());
      check("rand_empty", int'(o_empty), 1);
      cmp_log("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
